// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchroniser chain, per-channel debounce, rise/fall pulses.
// Optional press-toggle outputs are built when INPUT_COND_TOGGLE_EN is defined.
module input_conditioner #(
    parameter int                NUM_CH          = 8,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 400000,
    parameter logic [NUM_CH-1:0] RESET_VALUE     = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] async_in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] toggle
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] sync_s;

    // Synchroniser shift: pure flop-to-flop, nothing between stages.
    always_comb begin
        sync_d[0] = async_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Synchroniser chain registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_d = level_q;
        rise_d  = {NUM_CH{1'b0}};
        fall_d  = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = CNT_ZERO;
            if (sync_s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync_s[i];
                    rise_d[i]  = sync_s[i];
                    fall_d[i]  = ~sync_s[i];
                    cnt_d[i]   = CNT_ZERO;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = CNT_ZERO;
            end
        end
    end

    // Debounce state and edge-pulse registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= RESET_VALUE;
            rise_q  <= {NUM_CH{1'b0}};
            fall_q  <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef INPUT_COND_TOGGLE_EN
    logic [NUM_CH-1:0] toggle_q, toggle_d;

    // Toggle flips on the same edge that launches the rise pulse.
    always_comb begin
        toggle_d = toggle_q ^ rise_d;
    end

    // Toggle state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= {NUM_CH{1'b0}};
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign toggle = toggle_q;
`else
    assign toggle = {NUM_CH{1'b0}};
`endif

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel input conditioner for the game board's switches and buttons. It replaces the per-signal synchronizer instances at the top level with a single block. Each channel is synchronised into the `clock` domain, debounced with a per-channel stability counter, and delivered as:
- a clean level,
- single-cycle rise and fall pulses,
- optionally, a press-toggle state.

Player direction, move and reset controls all come from this block before they reach `draw_object` and the game logic.

## Interface
Parameters:
- `NUM_CH`, 8: number of independent input channels, ≥1.
- `SYNC_STAGES`, 2: flip-flops in each synchroniser chain, ≥2.
- `DEBOUNCE_CYCLES`, 400000: consecutive differing cycles required to accept a new level (10 ms at 40 MHz), ≥1.
- `RESET_VALUE`, '0: `NUM_CH`-bit value loaded into sync chains and `level` on reset.

Ports:
- `clock`, input, 1: pixel/system clock; all state is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `async_in`, input, `NUM_CH`: raw pins (SW/BTN), asynchronous to `clock`.
- `level`, output, `NUM_CH`: debounced, registered level.
- `rise`, output, `NUM_CH`: one-cycle pulse when `level[i]` goes 0→1.
- `fall`, output, `NUM_CH`: one-cycle pulse when `level[i]` goes 1→0.
- `toggle`, output, `NUM_CH`: flips on each `rise[i]`; constant 0 unless the toggle feature is compiled in.

## Operation
- Channels are fully independent. No state is shared except `clock` and `reset_n`.
- Sync stage: `async_in[i]` passes through a `SYNC_STAGES`-deep shift chain. `s[i]` is the last stage. No logic sits between stages.
- Debounce counter:
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s[i] == level[i]`, the counter clears to 0.
  - Otherwise it increments.
  - On an edge where `s[i] != level[i]` and the counter is `DEBOUNCE_CYCLES-1`:
    - `level[i]` takes `s[i]`;
    - the counter clears;
    - `rise[i]` or `fall[i]` is asserted for exactly that next cycle.
- Any return of `s[i]` to `level[i]` before the threshold discards the partial count. A bounce shorter than `DEBOUNCE_CYCLES` never changes `level`.
- The counter never wraps. It is bounded by the threshold compare.
- `rise` and `fall` of one channel are mutually exclusive. Different channels may pulse in the same cycle.
- Toggle (feature on): `toggle[i]` inverts on the same edge that asserts `rise[i]`. `fall` does not affect it.
- Reset (`reset_n` low, any time, including mid-count):
  - sync chain and `level` take `RESET_VALUE`;
  - counters, `rise`, `fall` and `toggle` go to 0;
  - all outputs change immediately, without waiting for a clock edge.
- Reset release: if an input differs from `RESET_VALUE`, `level` reaches it after the normal latency. The matching `rise` or `fall` pulse is emitted; this is intended.

## Timing
- Edge numbering: `async_in[i]` changes and is stable before edge 1, with no prior pending count.
  - `s[i]` shows the new value after edge `SYNC_STAGES`.
  - `level[i]` plus `rise`/`fall` update after edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- Pulse width: `rise`/`fall` deassert after the following edge.
- Throughput: one accepted transition per channel per `DEBOUNCE_CYCLES` cycles at most.
- `DEBOUNCE_CYCLES = 1` degenerates to synchronise plus edge detect, with latency `SYNC_STAGES + 1`.
- All outputs are direct flop outputs; there is no combinational path from `async_in`.

## Configuration
- Macro: `INPUT_COND_TOGGLE_EN`.
- Defined: per-channel toggle flops are built and `toggle` behaves as described in Operation.
- Undefined: no toggle flops are built and `toggle` is tied to all zeros. The port list is identical in both builds.

## Test plan
Bench parameters: `NUM_CH=4`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=8`, `RESET_VALUE=0`.

- **Reset hold:** `reset_n=0`, `async_in=4'hF`, with clocks running → `level`, `rise`, `fall` and `toggle` stay 0. Release → `level=4'hF` and `rise=4'hF` after edge 10; `rise=0` after edge 11.
- **Clean press:** `async_in[0]` 0→1 before edge 1 → `level[0]=1` and `rise[0]=1` after edge 10 only. Release 1→0 → `fall[0]` pulses 10 edges later.
- **Bounce:** `async_in[1]` inverts every 3 cycles for 30 cycles, then holds 1 → no `rise`/`fall` during the bounce. Exactly one `rise[1]` occurs 10 edges after the final change.
- **Simultaneous:** `async_in[2]` 0→1 and `async_in[3]` 1→0 (from settled states) on the same cycle → `rise[2]` and `fall[3]` in the same cycle; no other pulses.
- **Reset mid-count:** input change on channel 0, then `reset_n=0` 5 cycles after `s[0]` changes → outputs 0 immediately with no clock edge. After release, the full 10-edge latency restarts.
- **Toggle:** three clean presses on channel 0 → `toggle[0]` reads 1, 0, 1 after each `rise[0]` (macro defined). The same stimulus without the macro → `toggle` stays 4'h0.
